// File: rtl/serial_vram_cmd.sv
// Command packet decoder between the UART receiver and the VRAM write arbiter.
// Optional trailing checksum byte enabled by defining SERIAL_VRAM_CMD_CSUM_EN.
module serial_vram_cmd #(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned TIMEOUT_CLKS = 50000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_new_data_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CLKS + 1);

`ifdef SERIAL_VRAM_CMD_CSUM_EN
    typedef enum logic [2:0] {
        StHunt, StCmd, StAhi, StAlo, StData, StCsum, StIssue
    } state_e;
`else
    typedef enum logic [2:0] {
        StHunt, StCmd, StAhi, StAlo, StData, StIssue
    } state_e;
`endif

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        ahi_q, ahi_d;
    logic [7:0]        alo_q, alo_d;
`ifdef SERIAL_VRAM_CMD_CSUM_EN
    logic [7:0]        data_q, data_d;
`endif
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              err_q, err_d;

    logic              fin;
    logic              cmd_ok;
    logic              csum_ok;
    logic [7:0]        fin_data;
    logic              in_pkt;

    assign cmd_ok = (cmd_q == 8'h01) || (cmd_q == 8'h02);
    assign in_pkt = (state_q != StHunt) && (state_q != StIssue);

`ifdef SERIAL_VRAM_CMD_CSUM_EN
    assign csum_ok  = (rx_data_i == (cmd_q ^ ahi_q ^ alo_q ^ data_q));
    assign fin_data = data_q;
`else
    assign csum_ok  = 1'b1;
    assign fin_data = rx_data_i;
`endif

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        ahi_d     = ahi_q;
        alo_d     = alo_q;
`ifdef SERIAL_VRAM_CMD_CSUM_EN
        data_d    = data_q;
`endif
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ptr_d     = ptr_q;
        tmo_d     = tmo_q;
        err_d     = 1'b0;
        fin       = 1'b0;

        unique case (state_q)
            StHunt: begin
                if (rx_new_data_i && (rx_data_i == SYNC_BYTE)) state_d = StCmd;
            end
            StCmd: begin
                if (rx_new_data_i) begin
                    cmd_d   = rx_data_i;
                    state_d = StAhi;
                end
            end
            StAhi: begin
                if (rx_new_data_i) begin
                    ahi_d   = rx_data_i;
                    state_d = StAlo;
                end
            end
            StAlo: begin
                if (rx_new_data_i) begin
                    alo_d   = rx_data_i;
                    state_d = StData;
                end
            end
            StData: begin
`ifdef SERIAL_VRAM_CMD_CSUM_EN
                if (rx_new_data_i) begin
                    data_d  = rx_data_i;
                    state_d = StCsum;
                end
            end
            StCsum: begin
`endif
                fin = rx_new_data_i;
            end
            StIssue: begin
                // Overrun: the byte is dropped, the pending write is untouched.
                if (rx_new_data_i) err_d = 1'b1;
                if (wr_ready_i) begin
                    ptr_d   = wr_addr_q + ADDR_W'(1);
                    state_d = StHunt;
                end
            end
            default: state_d = StHunt;
        endcase

        if (fin) begin
            if (cmd_ok && csum_ok) begin
                state_d   = StIssue;
                wr_data_d = fin_data;
                wr_addr_d = (cmd_q == 8'h01) ? ADDR_W'({ahi_q, alo_q}) : ptr_q;
            end else begin
                err_d   = 1'b1;
                state_d = StHunt;
            end
        end

        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (in_pkt) begin
            if (rx_new_data_i) begin
                tmo_d = '0;
            end else if (tmo_q == TmoW'(TIMEOUT_CLKS - 1)) begin
                tmo_d   = '0;
                err_d   = 1'b1;
                state_d = StHunt;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StHunt;
            cmd_q     <= '0;
            ahi_q     <= '0;
            alo_q     <= '0;
`ifdef SERIAL_VRAM_CMD_CSUM_EN
            data_q    <= '0;
`endif
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ptr_q     <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            ahi_q     <= ahi_d;
            alo_q     <= alo_d;
`ifdef SERIAL_VRAM_CMD_CSUM_EN
            data_q    <= data_d;
`endif
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ptr_q     <= ptr_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
        end
    end

    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign wr_valid_o = (state_q == StIssue);
    assign busy_o     = (state_q != StHunt);
    assign err_o      = err_q;

endmodule

// File: tb/tb_serial_vram_cmd.sv
// Bench for serial_vram_cmd: packet-level reference model checked every cycle,
// plus directed packets with literal expected writes and error counts.
`timescale 1ns/1ps
module tb_serial_vram_cmd;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned TMO    = 64;
`ifdef SERIAL_VRAM_CMD_CSUM_EN
    localparam int PKT_LEN = 6;
    localparam int EXP_ERRS = 5;
`else
    localparam int PKT_LEN = 5;
    localparam int EXP_ERRS = 4;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_new = 1'b0;
    logic              wr_ready = 1'b1;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_valid;
    logic              busy;
    logic              err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_vram_cmd #(
        .ADDR_W       (ADDR_W),
        .TIMEOUT_CLKS (TMO),
        .SYNC_BYTE    (8'hA5)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rx_data_i     (rx_data),
        .rx_new_data_i (rx_new),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .wr_valid_o    (wr_valid),
        .wr_ready_i    (wr_ready),
        .busy_o        (busy),
        .err_o         (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects packet bytes in a list and judges the whole packet.
    logic [7:0]        m_pkt[$];
    logic [ADDR_W+7:0] m_log[$];
    bit                m_pend = 1'b0;
    bit                m_err = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [ADDR_W-1:0] m_ptr = '0;
    logic [7:0]        m_data = '0;
    int                m_idle = 0;
    int                m_err_cnt = 0;
    int                dut_err_cnt = 0;

    task automatic finish_pkt();
        bit ok;
        ok = (m_pkt[1] == 8'h01) || (m_pkt[1] == 8'h02);
`ifdef SERIAL_VRAM_CMD_CSUM_EN
        if (m_pkt[5] != (m_pkt[1] ^ m_pkt[2] ^ m_pkt[3] ^ m_pkt[4])) ok = 1'b0;
`endif
        if (ok) begin
            m_pend = 1'b1;
            m_data = m_pkt[4];
            m_addr = (m_pkt[1] == 8'h01) ? ADDR_W'({m_pkt[2], m_pkt[3]}) : m_ptr;
        end else begin
            m_err = 1'b1;
        end
        m_pkt.delete();
    endtask

    task automatic model_step();
        m_err = 1'b0;
        if (rst) begin
            m_pkt.delete();
            m_pend = 1'b0;
            m_ptr  = '0;
            m_idle = 0;
        end else if (m_pend) begin
            if (rx_new) m_err = 1'b1;
            if (wr_ready) begin
                m_log.push_back({m_addr, m_data});
                m_ptr  = m_addr + 1'b1;
                m_pend = 1'b0;
            end
        end else if (m_pkt.size() == 0) begin
            if (rx_new && rx_data == 8'hA5) begin
                m_pkt.push_back(rx_data);
                m_idle = 0;
            end
        end else if (rx_new) begin
            m_pkt.push_back(rx_data);
            m_idle = 0;
            if (m_pkt.size() == PKT_LEN) finish_pkt();
        end else begin
            m_idle++;
            if (m_idle == TMO) begin
                m_err = 1'b1;
                m_pkt.delete();
                m_idle = 0;
            end
        end
        if (m_err) m_err_cnt++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("cyc_wr_valid", wr_valid, m_pend);
            chk("cyc_busy", busy, (m_pend || m_pkt.size() != 0));
            chk("cyc_err", err, m_err);
            if (m_pend) begin
                chk("cyc_wr_addr", wr_addr, m_addr);
                chk("cyc_wr_data", wr_data, m_data);
            end
            if (err === 1'b1) dut_err_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_new  = 1'b1;
        @(negedge clk);
        rx_new  = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic send_pkt(input logic [7:0] cmd, input logic [7:0] ahi,
                            input logic [7:0] alo, input logic [7:0] dat);
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(ahi);
        send_byte(alo);
        send_byte(dat);
`ifdef SERIAL_VRAM_CMD_CSUM_EN
        send_byte(cmd ^ ahi ^ alo ^ dat);
`endif
    endtask

    task automatic chk_log(input string name, input int idx, input logic [ADDR_W+7:0] exp);
        chk(name, (idx < m_log.size()) ? 32'(m_log[idx]) : 32'hFFFF_FFFF, 32'(exp));
    endtask

    int e0;

    initial begin
        idle(3);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        idle(2);

        // Absolute write, one-cycle valid with ready already high.
        send_pkt(8'h01, 8'h03, 8'hE8, 8'h41);
        chk("t1_valid", wr_valid, 1);
        chk("t1_addr", wr_addr, 11'h3E8);
        chk("t1_data", wr_data, 8'h41);
        idle(1);
        chk("t1_drop", wr_valid, 0);
        idle(2);
        chk_log("t1_log", 0, {11'h3E8, 8'h41});

        // Pointer writes after an absolute write.
        send_pkt(8'h02, 8'h55, 8'h66, 8'h42);
        idle(2);
        send_pkt(8'h02, 8'h00, 8'h00, 8'h42);
        chk("t2_addr", wr_addr, 11'h3EA);
        idle(2);
        chk_log("t2_log_a", 1, {11'h3E9, 8'h42});
        chk_log("t2_log_b", 2, {11'h3EA, 8'h42});

        // Pointer wraps from all-ones to zero.
        send_pkt(8'h01, 8'h07, 8'hFF, 8'h20);
        idle(2);
        send_pkt(8'h02, 8'h00, 8'h00, 8'h21);
        chk("t3_wrap_addr", wr_addr, 11'h000);
        idle(2);
        chk_log("t3_log_a", 3, {11'h7FF, 8'h20});
        chk_log("t3_log_b", 4, {11'h000, 8'h21});

        // Back-pressure with an overrun byte in the middle.
        wr_ready = 1'b0;
        send_pkt(8'h01, 8'h01, 8'h23, 8'h5A);
        idle(50);
        send_byte(8'h77);
        chk("t4_ovr_err", err, 1);
        idle(49);
        chk("t4_hold_valid", wr_valid, 1);
        chk("t4_hold_addr", wr_addr, 11'h123);
        chk("t4_hold_data", wr_data, 8'h5A);
        wr_ready = 1'b1;
        idle(1);
        chk("t4_drop", wr_valid, 0);
        idle(2);
        chk_log("t4_log", 5, {11'h123, 8'h5A});

        // Timeout mid-packet, then a clean packet.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        idle(TMO - 1);
        chk("t5_pre_busy", busy, 1);
        chk("t5_pre_err", err, 0);
        idle(1);
        chk("t5_tmo_err", err, 1);
        chk("t5_tmo_busy", busy, 0);
        idle(2);
        send_pkt(8'h01, 8'h00, 8'h10, 8'h55);
        idle(2);
        chk_log("t5_log", 6, {11'h010, 8'h55});

        // Garbage in hunt is silent; unknown command is consumed then flagged.
        #1 e0 = dut_err_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        idle(2);
        #1 chk("t6_garbage_errs", dut_err_cnt, e0);
        chk("t6_garbage_busy", busy, 0);
        send_pkt(8'h07, 8'h00, 8'h00, 8'h00);
        chk("t6_badcmd_err", err, 1);
        chk("t6_badcmd_valid", wr_valid, 0);
        idle(2);
`ifdef SERIAL_VRAM_CMD_CSUM_EN
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h05);
        chk("t6_csum_err", err, 1);
        chk("t6_csum_valid", wr_valid, 0);
        idle(2);
`endif
        chk("t6_log_size", m_log.size(), 7);

        // Byte on the expiry cycle beats the timeout.
        send_byte(8'hA5);
        idle(TMO - 1);
        send_byte(8'h01);
        chk("t7_race_err", err, 0);
        chk("t7_race_busy", busy, 1);
        idle(TMO);
        chk("t7_tmo_err", err, 1);
        chk("t7_tmo_busy", busy, 0);
        idle(2);

        // Reset during a pending write discards it and clears the pointer.
        wr_ready = 1'b0;
        send_pkt(8'h01, 8'h00, 8'h20, 8'h66);
        chk("t8_valid", wr_valid, 1);
        rst = 1'b1;
        idle(1);
        chk("t8_rst_valid", wr_valid, 0);
        chk("t8_rst_busy", busy, 0);
        rst = 1'b0;
        wr_ready = 1'b1;
        idle(2);
        chk("t8_log_size", m_log.size(), 7);
        send_pkt(8'h02, 8'h00, 8'h00, 8'h77);
        chk("t8_ptr_addr", wr_addr, 11'h000);
        idle(2);
        chk_log("t8_log", 7, {11'h000, 8'h77});

        #1;
        chk("model_err_count", m_err_cnt, EXP_ERRS);
        chk("dut_err_count", dut_err_cnt, EXP_ERRS);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
